mem_port_arbiter: RTL and testbench

- Shares the single off-chip memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the memory model, below the pipeline's memory_stall generation.
- Sequences one transaction at a time, registers all memory-side signals, and returns read data with a one-cycle ready pulse.
- Resolves simultaneous requests with alternating priority and aborts hung transactions with a watchdog.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache/memory handshake bundle for the memory port arbiter
// Purpose: groups the I-cache, D-cache, memory and status signals of mem_port_arbiter.
// Modports:
//   slave  - arbiter side: takes cache requests and memory responses, drives
//            read data, ready pulses, memory strobes and status.
//   master - environment side (caches + memory model): the mirror of slave.
interface mem_port_arbiter_if #(
  parameter int AW = 28,
  parameter int DW = 128
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          timeout_err;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
           mem_wdata, timeout_err, busy
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
           mem_wdata, timeout_err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one line-addressed memory port between I-cache and D-cache
// Purpose: one transaction at a time, alternating priority on conflicts,
// registered memory-side signals, one-cycle ready pulse, sticky watchdog abort.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: cache requests/responses, memory strobes,
//          memory response, timeout_err and busy status
module mem_port_arbiter #(
  parameter int AW      = 28,
  parameter int DW      = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_pri_d;
  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout_err;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_i_ready;
  logic          r_d_ready;

  logic w_d_pend;
  logic w_grant_d;

  assign w_d_pend  = bus.d_read | bus.d_write;
  // D wins when it is alone, or when both request and it holds priority.
  assign w_grant_d = w_d_pend & (~bus.i_req | r_pri_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pri_d       <= 1'b1;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_ready     <= 1'b0;
      r_d_ready     <= 1'b0;
    end else begin
      // Ready is a single-cycle pulse, raised only on entry to RESP.
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wd_cnt <= '0;
          if (w_grant_d) begin
            r_state     <= S_BUSY_D;
            r_pri_d     <= 1'b0;
            r_mem_write <= bus.d_write;   // write wins over a simultaneous read
            r_mem_read  <= ~bus.d_write;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
          end else if (bus.i_req) begin
            r_state     <= S_BUSY_I;
            r_pri_d     <= 1'b1;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= bus.i_addr;
            r_mem_wdata <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (bus.mem_ready) begin
            r_state     <= S_RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_state == S_BUSY_I) begin
              r_i_rdata <= bus.mem_rdata;
              r_i_ready <= 1'b1;
            end else begin
              // A write returns no data; d_rdata keeps its last read line.
              if (!r_mem_write) r_d_rdata <= bus.mem_rdata;
              r_d_ready <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (r_wd_cnt == WD_LAST)) begin
            r_state       <= S_RESP;
            r_timeout_err <= 1'b1;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            if (r_state == S_BUSY_I) begin
              r_i_rdata <= '0;
              r_i_ready <= 1'b1;
            end else begin
              r_d_rdata <= '0;
              r_d_ready <= 1'b1;
            end
          end else begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
          end
        end
        default: begin
          // RESP: requests are ignored so the requester can drop them now.
          r_state  <= S_IDLE;
          r_wd_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.i_rdata     = r_i_rdata;
  assign bus.i_ready     = r_i_ready;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.d_ready     = r_d_ready;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: raises mem_ready once the strobe has been visible for lat+1 cycles.
  int   lat = -1;
  int   scnt = 0;
  logic auto_ready = 1'b0;
  logic force_ready = 1'b0;
  assign bus.mem_ready = auto_ready | force_ready;

  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      scnt = scnt + 1;
      auto_ready = (lat >= 0) && (scnt == lat + 1);
    end else begin
      scnt = 0;
      auto_ready = 1'b0;
    end
  end

  // Transaction-level model: phase 0=idle, 1=memory access, 2=response.
  logic          m_init = 1'b0;
  int            m_phase;
  logic          m_side_d;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_age;
  logic          m_pri_d;
  logic          m_err;
  logic [DW-1:0] m_irdata, m_drdata;

  always @(posedge clk) begin
    if (rst) begin
      m_init   <= 1'b1;
      m_phase  <= 0;
      m_pri_d  <= 1'b1;
      m_err    <= 1'b0;
      m_irdata <= '0;
      m_drdata <= '0;
      m_age    <= 0;
      m_side_d <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else if (m_phase == 0) begin
      if (bus.d_read || bus.d_write || bus.i_req) begin
        logic take_d;
        take_d = (bus.d_read || bus.d_write) && (!bus.i_req || m_pri_d);
        m_phase  <= 1;
        m_age    <= 0;
        m_side_d <= take_d;
        m_pri_d  <= !take_d;
        m_wr     <= take_d && bus.d_write;
        m_addr   <= take_d ? bus.d_addr : bus.i_addr;
        m_wdata  <= take_d ? bus.d_wdata : '0;
      end
    end else if (m_phase == 1) begin
      if (bus.mem_ready) begin
        m_phase <= 2;
        if (!m_side_d) m_irdata <= bus.mem_rdata;
        else if (!m_wr) m_drdata <= bus.mem_rdata;
      end else if (TO != 0 && m_age + 1 == TO) begin
        m_phase <= 2;
        m_err   <= 1'b1;
        if (!m_side_d) m_irdata <= '0;
        else m_drdata <= '0;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("mem_read",    bus.mem_read,    m_phase == 1 && !m_wr);
      chk("mem_write",   bus.mem_write,   m_phase == 1 && m_wr);
      chk("mem_addr",    bus.mem_addr,    m_phase == 1 ? m_addr : '0);
      chk("mem_wdata",   bus.mem_wdata,   m_phase == 1 ? m_wdata : '0);
      chk("i_ready",     bus.i_ready,     m_phase == 2 && !m_side_d);
      chk("d_ready",     bus.d_ready,     m_phase == 2 && m_side_d);
      chk("i_rdata",     bus.i_rdata,     m_irdata);
      chk("d_rdata",     bus.d_rdata,     m_drdata);
      chk("timeout_err", bus.timeout_err, m_err);
      chk("busy",        bus.busy,        m_phase != 0);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [DW-1:0] pat_a, pat_5, pat_c, pat_w;

  initial begin
    pat_a = {32{4'hA}};
    pat_5 = {32{4'h5}};
    pat_c = {16{8'hC3}};
    pat_w = {8{16'h1234}};
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    nclk(3);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.timeout_err, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_i_rdata", bus.i_rdata, '0);
    rst = 1'b0;

    // I-cache read alone, memory ready 4 cycles after the strobe.
    nclk(1);
    bus.i_addr = 28'h0000010; bus.i_req = 1; lat = 4; bus.mem_rdata = pat_a;
    nclk(1);
    chk("t1_strobe", bus.mem_read, 1'b1);
    chk("t1_addr", bus.mem_addr, 28'h0000010);
    nclk(5);
    chk("t1_i_ready", bus.i_ready, 1'b1);
    chk("t1_i_rdata", bus.i_rdata, pat_a);
    chk("t1_d_ready", bus.d_ready, 1'b0);
    bus.i_req = 0;
    nclk(2);

    // Conflicts from reset: D, then I, then D again.
    rst = 1'b1; nclk(2); rst = 1'b0;
    bus.i_req = 1; bus.i_addr = 28'h0000111;
    bus.d_read = 1; bus.d_addr = 28'h0000222; lat = 0; bus.mem_rdata = pat_5;
    nclk(1);
    chk("t2_first_addr", bus.mem_addr, 28'h0000222);
    nclk(1);
    chk("t2_first_d_ready", bus.d_ready, 1'b1);
    nclk(2);
    chk("t2_second_addr", bus.mem_addr, 28'h0000111);
    nclk(1);
    chk("t2_second_i_ready", bus.i_ready, 1'b1);
    nclk(2);
    chk("t2_third_addr", bus.mem_addr, 28'h0000222);
    bus.i_req = 0; bus.d_read = 0;
    nclk(1);
    chk("t2_third_d_ready", bus.d_ready, 1'b1);
    nclk(1);

    // D write, ready after one cycle; d_rdata unchanged.
    bus.d_write = 1; bus.d_addr = 28'h0000123; bus.d_wdata = pat_w; lat = 1;
    nclk(1);
    chk("t3_mem_write", bus.mem_write, 1'b1);
    chk("t3_mem_read", bus.mem_read, 1'b0);
    chk("t3_wdata", bus.mem_wdata, pat_w);
    nclk(2);
    chk("t3_d_ready", bus.d_ready, 1'b1);
    chk("t3_d_rdata_kept", bus.d_rdata, pat_5);
    bus.d_write = 0;
    nclk(1);

    // Watchdog: D read never answered.
    bus.d_read = 1; bus.d_addr = 28'h0000300; lat = -1;
    nclk(8);
    chk("t4_strobe_last", bus.mem_read, 1'b1);
    nclk(1);
    chk("t4_strobe_drop", bus.mem_read, 1'b0);
    chk("t4_d_ready", bus.d_ready, 1'b1);
    chk("t4_d_rdata", bus.d_rdata, '0);
    chk("t4_err", bus.timeout_err, 1'b1);
    bus.d_read = 0;
    nclk(1);
    bus.i_req = 1; bus.i_addr = 28'h0000040; lat = 2; bus.mem_rdata = pat_c;
    nclk(4);
    chk("t4_i_ready", bus.i_ready, 1'b1);
    chk("t4_i_rdata", bus.i_rdata, pat_c);
    chk("t4_err_sticky", bus.timeout_err, 1'b1);
    bus.i_req = 0;
    nclk(1);

    // Reset during BUSY_I, then a stray mem_ready in IDLE.
    bus.i_req = 1; bus.i_addr = 28'h0000055; lat = -1;
    nclk(2);
    chk("t5_busy_before", bus.busy, 1'b1);
    rst = 1'b1; bus.i_req = 0;
    nclk(1);
    rst = 1'b0; force_ready = 1'b1;
    nclk(1);
    force_ready = 1'b0;
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_i_ready", bus.i_ready, 1'b0);
    chk("t5_err", bus.timeout_err, 1'b0);
    chk("t5_mem_read", bus.mem_read, 1'b0);
    nclk(1);

    // Read and write together: write is issued.
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 28'h0000077; bus.d_wdata = pat_c; lat = 0;
    nclk(1);
    chk("t6_mem_write", bus.mem_write, 1'b1);
    chk("t6_mem_read", bus.mem_read, 1'b0);
    nclk(1);
    chk("t6_d_ready", bus.d_ready, 1'b1);
    bus.d_read = 0; bus.d_write = 0;
    nclk(2);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
